// File: rtl/mesh_router_buf.sv
// Buffered 5-port XY mesh router node: input FIFOs, per-output round-robin arbiter, registered output.
// Latency: flit accepted at edge k into an empty FIFO with a free output appears after edge k+1.
// Backpressure: in_ready drops when an input FIFO is full; a stalled output holds its flit and pops nothing.
module mesh_router_buf #(
    parameter int X_POS      = 1,
    parameter int Y_POS      = 1,
    parameter int COORD_W    = 16,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int FLIT_W    = 2 * COORD_W + DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5*FLIT_W-1:0] in_flit,
    input  logic [4:0]          in_valid,
    output logic [4:0]          in_ready,
    output logic [5*FLIT_W-1:0] out_flit,
    output logic [4:0]          out_valid,
    input  logic [4:0]          out_ready,
    output logic [15:0]         local_rx_count
);

    localparam int NP    = 5;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [COORD_W-1:0] X_C = COORD_W'(X_POS);
    localparam logic [COORD_W-1:0] Y_C = COORD_W'(Y_POS);

    // Input FIFO state
    logic [FLIT_W-1:0] mem_q [NP][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [NP];
    logic [PTR_W-1:0]  wr_ptr_d [NP];
    logic [PTR_W-1:0]  rd_ptr_q [NP];
    logic [PTR_W-1:0]  rd_ptr_d [NP];
    logic [CNT_W-1:0]  cnt_q [NP];
    logic [CNT_W-1:0]  cnt_d [NP];

    // Output stage and arbiter state
    logic [FLIT_W-1:0] out_flit_q [NP];
    logic [FLIT_W-1:0] out_flit_d [NP];
    logic [NP-1:0]     out_valid_q;
    logic [NP-1:0]     out_valid_d;
    logic [2:0]        rr_ptr_q [NP];
    logic [2:0]        rr_ptr_d [NP];
    logic [15:0]       rx_cnt_q;
    logic [15:0]       rx_cnt_d;

    // Combinational helpers
    logic [NP-1:0]      full;
    logic [NP-1:0]      empty;
    logic [NP-1:0]      push;
    logic [NP-1:0]      pop;
    logic [NP-1:0]      stage_free;
    logic [FLIT_W-1:0]  head [NP];
    logic [COORD_W-1:0] head_x [NP];
    logic [COORD_W-1:0] head_y [NP];
    logic [2:0]         route [NP];
    logic [NP-1:0]      gnt_vld;
    logic [2:0]         gnt_idx [NP];

    // Next index in the circular search order, (base + k) mod 5
    function automatic logic [2:0] wrap5(input logic [2:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NP) s = s - NP;
        return 3'(s);
    endfunction

    for (genvar p = 0; p < NP; p++) begin : g_port
        assign full[p]       = (cnt_q[p] == CNT_W'(FIFO_DEPTH));
        assign empty[p]      = (cnt_q[p] == '0);
        assign in_ready[p]   = !full[p] && !rst;
        assign push[p]       = in_valid[p] && in_ready[p];
        assign head[p]       = mem_q[p][rd_ptr_q[p]];
        assign head_y[p]     = head[p][FLIT_W-1 -: COORD_W];
        assign head_x[p]     = head[p][DATA_W +: COORD_W];
        assign stage_free[p] = !out_valid_q[p] || out_ready[p];
        assign out_flit[p*FLIT_W +: FLIT_W] = out_flit_q[p];
    end

    assign out_valid      = out_valid_q;
    assign local_rx_count = rx_cnt_q;

    // XY dimension-order route for every FIFO head: X first, then Y, else local
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            route[p] = 3'd0;
            if (X_C < head_x[p])      route[p] = 3'd2;
            else if (X_C > head_x[p]) route[p] = 3'd1;
            else if (Y_C < head_y[p]) route[p] = 3'd3;
            else if (Y_C > head_y[p]) route[p] = 3'd4;
        end
    end

    // Round-robin grant per output, searching from the input after the last winner
    always_comb begin
        for (int o = 0; o < NP; o++) begin
            gnt_vld[o] = 1'b0;
            gnt_idx[o] = 3'd0;
            for (int k = 1; k <= NP; k++) begin
                if (stage_free[o] && !gnt_vld[o] && !empty[wrap5(rr_ptr_q[o], k)]
                    && route[wrap5(rr_ptr_q[o], k)] == 3'(o)) begin
                    gnt_vld[o] = 1'b1;
                    gnt_idx[o] = wrap5(rr_ptr_q[o], k);
                end
            end
        end
    end

    // A head routes to exactly one output, so each input sees at most one grant
    always_comb begin
        pop = '0;
        for (int o = 0; o < NP; o++) begin
            if (gnt_vld[o]) pop[gnt_idx[o]] = 1'b1;
        end
    end

    // Next-state for FIFO pointers, output stages, arbiter pointers and local counter
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            wr_ptr_d[p] = wr_ptr_q[p] + PTR_W'(push[p]);
            rd_ptr_d[p] = rd_ptr_q[p] + PTR_W'(pop[p]);
            cnt_d[p]    = cnt_q[p] + CNT_W'(push[p]) - CNT_W'(pop[p]);
        end
        for (int o = 0; o < NP; o++) begin
            out_valid_d[o] = out_valid_q[o];
            out_flit_d[o]  = out_flit_q[o];
            rr_ptr_d[o]    = rr_ptr_q[o];
            if (stage_free[o]) begin
                out_valid_d[o] = gnt_vld[o];
                if (gnt_vld[o]) begin
                    out_flit_d[o] = head[gnt_idx[o]];
                    rr_ptr_d[o]   = gnt_idx[o];
                end
            end
        end
        rx_cnt_d = rx_cnt_q + 16'(out_valid_q[0] && out_ready[0]);
    end

    // State registers; reset empties FIFOs, clears outputs, points arbiters at input 4
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= '0;
            rx_cnt_q    <= '0;
            for (int p = 0; p < NP; p++) begin
                wr_ptr_q[p]   <= '0;
                rd_ptr_q[p]   <= '0;
                cnt_q[p]      <= '0;
                out_flit_q[p] <= '0;
                rr_ptr_q[p]   <= 3'd4;
            end
        end else begin
            out_valid_q <= out_valid_d;
            rx_cnt_q    <= rx_cnt_d;
            for (int p = 0; p < NP; p++) begin
                wr_ptr_q[p]   <= wr_ptr_d[p];
                rd_ptr_q[p]   <= rd_ptr_d[p];
                cnt_q[p]      <= cnt_d[p];
                out_flit_q[p] <= out_flit_d[p];
                rr_ptr_q[p]   <= rr_ptr_d[p];
            end
        end
    end

    // FIFO storage write; push is already blocked during reset
    always_ff @(posedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (push[p]) mem_q[p][wr_ptr_q[p]] <= in_flit[p*FLIT_W +: FLIT_W];
        end
    end

endmodule

// File: tb/tb_mesh_router_buf.sv
// Scoreboard bench for mesh_router_buf at node (1,1): directed vectors, per-output expected queues.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// A monitor pops the expected queue of an output on every valid&ready transfer.
module tb_mesh_router_buf;
    localparam int FW = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [5*FW-1:0] in_flit;
    logic [4:0]      in_valid;
    logic [4:0]      in_ready;
    logic [5*FW-1:0] out_flit;
    logic [4:0]      out_valid;
    logic [4:0]      out_ready;
    logic [15:0]     local_rx_count;

    always #5 clk = ~clk;

    mesh_router_buf #(
        .X_POS(1), .Y_POS(1), .COORD_W(16), .DATA_W(32), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
        .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
        .local_rx_count(local_rx_count)
    );

    logic [FW-1:0] exp_q [5][$];
    logic [FW-1:0] mon_e;
    logic [FW-1:0] d_f [5];
    int            d_o [5];
    int            tests = 0;
    int            fails = 0;

    function automatic logic [FW-1:0] mk(input logic [15:0] y, input logic [15:0] x,
                                          input logic [31:0] d);
        return {y, x, d};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Present one cycle of flits on the ports in m; record accepted flits in the scoreboard
    task automatic send(input logic [4:0] m);
        for (int p = 0; p < 5; p++) in_flit[p*FW +: FW] = d_f[p];
        in_valid = m;
        @(negedge clk);
        for (int p = 0; p < 5; p++) begin
            if (m[p]) begin
                chk($sformatf("accept_p%0d", p), 64'(in_ready[p]), 64'd1);
                if (in_ready[p]) exp_q[d_o[p]].push_back(d_f[p]);
            end
        end
        @(posedge clk); #1;
        in_valid = '0;
    endtask

    // Monitor: every completed output transfer must match the head of its expected queue
    always @(negedge clk) begin
        if (!rst) begin
            for (int o = 0; o < 5; o++) begin
                if (out_valid[o] && out_ready[o]) begin
                    tests++;
                    if (exp_q[o].size() == 0) begin
                        fails++;
                        $display("FAIL out%0d_unexpected: got %h, expected no flit", o,
                                 out_flit[o*FW +: FW]);
                    end else begin
                        mon_e = exp_q[o].pop_front();
                        if (out_flit[o*FW +: FW] !== mon_e) begin
                            fails++;
                            $display("FAIL out%0d_flit: got %h, expected %h", o,
                                     out_flit[o*FW +: FW], mon_e);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int sent;
        int cyc;
        rst = 1'b1; in_valid = '0; in_flit = '0; out_ready = '1;
        for (int p = 0; p < 5; p++) begin d_f[p] = '0; d_o[p] = 0; end
        repeat (2) @(posedge clk); #1;
        chk("in_ready_in_reset", 64'(in_ready), 64'h0);
        rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("reset_out_valid", 64'(out_valid), 64'h0);
        chk("reset_in_ready", 64'(in_ready), 64'h1f);
        chk("reset_rx_count", 64'(local_rx_count), 64'h0);

        // Single flit local -> right, one-cycle pulse after edge k+1
        d_f[0] = mk(16'd1, 16'd3, 32'hDEAD_BEEF); d_o[0] = 2;
        send(5'b00001);
        chk("lat_after_k", 64'(out_valid), 64'h0);
        @(posedge clk); #1;
        chk("lat_after_k1_valid", 64'(out_valid), 64'h04);
        chk("lat_after_k1_flit", out_flit[2*FW +: FW], mk(16'd1, 16'd3, 32'hDEAD_BEEF));
        @(posedge clk); #1;
        chk("lat_pulse_end", 64'(out_valid), 64'h0);

        // Three inputs to local in one cycle: round robin gives left, up, down
        for (int r = 0; r < 2; r++) begin
            d_f[1] = mk(16'd1, 16'd1, 32'h1111_0000 + 32'(r)); d_o[1] = 0;
            d_f[3] = mk(16'd1, 16'd1, 32'h3333_0000 + 32'(r)); d_o[3] = 0;
            d_f[4] = mk(16'd1, 16'd1, 32'h4444_0000 + 32'(r)); d_o[4] = 0;
            send(5'b11010);
            @(posedge clk); #1;
            chk("rr_first_left", out_flit[0 +: FW], mk(16'd1, 16'd1, 32'h1111_0000 + 32'(r)));
            @(posedge clk); #1;
            chk("rr_second_up", out_flit[0 +: FW], mk(16'd1, 16'd1, 32'h3333_0000 + 32'(r)));
            @(posedge clk); #1;
            chk("rr_third_down", out_flit[0 +: FW], mk(16'd1, 16'd1, 32'h4444_0000 + 32'(r)));
            @(posedge clk); #1;
            chk("rr_rx_count", 64'(local_rx_count), 64'(3 * (r + 1)));
        end

        // Backpressure on right: 1 flit in the output register, 4 fill the left FIFO
        out_ready = 5'b11011;
        for (int i = 0; i < 5; i++) begin
            d_f[1] = mk(16'd1, 16'd5, 32'hA0 + 32'(i)); d_o[1] = 2;
            send(5'b00010);
        end
        chk("bp_in_ready", 64'(in_ready), 64'h1d);
        chk("bp_out_valid", 64'(out_valid), 64'h04);
        chk("bp_held_flit", out_flit[2*FW +: FW], mk(16'd1, 16'd5, 32'hA0));
        out_ready = '1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_stream_valid", 64'(out_valid[2]), 64'd1);
        end
        @(negedge clk);
        chk("bp_stream_end", 64'(out_valid[2]), 64'd0);
        @(posedge clk); #1;

        // Reset mid-operation: 1 flit held on up output, 3 in the local FIFO
        out_ready = 5'b10111;
        for (int i = 0; i < 4; i++) begin
            d_f[0] = mk(16'd5, 16'd1, 32'hB0 + 32'(i)); d_o[0] = 3;
            send(5'b00001);
        end
        chk("pre_rst_out_valid", 64'(out_valid), 64'h08);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h0);
        for (int o = 0; o < 5; o++) exp_q[o].delete();
        rst = 1'b0;
        out_ready = '1;
        repeat (10) @(posedge clk); #1;
        chk("post_rst_out_valid", 64'(out_valid), 64'h0);
        chk("post_rst_rx_count", 64'(local_rx_count), 64'h0);

        // Local loopback stream: 65535 flits then one more wraps the counter
        sent = 0; cyc = 0;
        in_valid = 5'b00001;
        while (sent < 65535 && cyc < 70000) begin
            in_flit[0 +: FW] = mk(16'd1, 16'd1, 32'(sent));
            @(negedge clk);
            if (in_ready[0]) begin
                exp_q[0].push_back(mk(16'd1, 16'd1, 32'(sent)));
                sent++;
            end
            cyc++;
            @(posedge clk); #1;
        end
        in_valid = '0;
        chk("stream_sent", 64'(sent), 64'd65535);
        repeat (5) @(posedge clk); #1;
        chk("rx_count_ffff", 64'(local_rx_count), 64'hFFFF);
        d_f[0] = mk(16'd1, 16'd1, 32'hFFFF_FFFF); d_o[0] = 0;
        send(5'b00001);
        repeat (4) @(posedge clk); #1;
        chk("rx_count_wrap", 64'(local_rx_count), 64'h0);

        for (int o = 0; o < 5; o++) chk($sformatf("drain_out%0d", o), 64'(exp_q[o].size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mesh_router_buf.md
Name: mesh_router_buf

Overview:
- Clocked, buffered successor to the combinational XY mesh router.
- One node of a 2-D mesh with five ports: local CPU, left, right, up, down.
- Each input port has a FIFO. Each output port has a round-robin arbiter and a registered output stage with a valid/ready handshake.
- Flit layout keeps the existing packing: {dest_y, dest_x, data}.

Parameters:
- X_POS, 1, this node's x coordinate
- Y_POS, 1, this node's y coordinate
- COORD_W, 16, width of each coordinate field
- DATA_W, 32, payload width
- FIFO_DEPTH, 4, entries per input FIFO; must be a power of two and ≥2
- Derived: FLIT_W = 2*COORD_W + DATA_W. Layout is [FLIT_W-1 -: COORD_W] = y, next COORD_W = x, [DATA_W-1:0] = data.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- in_flit  in  5*FLIT_W  input flits; slice p belongs to port p (0=local, 1=left, 2=right, 3=up, 4=down)
- in_valid  in  5  input flit valid, per port
- in_ready  out  5  input port can accept, per port
- out_flit  out  5*FLIT_W  output flits, same port indexing
- out_valid  out  5  output flit valid
- out_ready  in  5  downstream accepts
- local_rx_count  out  16  count of flits delivered on port 0; wraps at 16'hFFFF→0

Behaviour:
- Reset (rst=1 at an edge):
  - All FIFOs empty.
  - out_valid=0, out_flit=0, local_rx_count=0.
  - Every rr_ptr = 4, so input 0 has first priority.
  - in_ready=0 while rst is high.
- Input handshake: a transfer occurs on an edge where in_valid[p] && in_ready[p].
  - in_ready[p] = !full[p] && !rst. It is combinational from the FIFO count.
  - There is no push-while-full bypass: a full FIFO deasserts ready even if it pops in the same cycle.
- FIFO: standard circular buffer, wr/rd pointers log2(FIFO_DEPTH) bits wide, count 0..FIFO_DEPTH.
  - Push and pop on the same edge leave count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Route computation is combinational on each non-empty FIFO head, comparing unsigned coordinates:
  - X_POS < dx → right (2)
  - else X_POS > dx → left (1)
  - else Y_POS < dy → up (3)
  - else Y_POS > dy → down (4)
  - else → local (0). This includes local→local loopback.
- Output stage o is free when !out_valid[o] || out_ready[o].
- Arbitration per output o:
  - Requesters are inputs whose non-empty head routes to o.
  - Search order starts at (rr_ptr[o]+1) mod 5 and is ascending with wrap.
  - If the stage is free and at least one requester exists, the first requester in search order wins:
    - the winning head is popped;
    - its flit is loaded into out_flit[o] and out_valid[o]=1 on the same edge;
    - rr_ptr[o] takes the winner's index.
  - If the stage is free with no requesters, out_valid[o] clears on a consumed flit.
  - If the stage is not free, it holds out_flit/out_valid unchanged; no pop and no pointer change.
- One input can be granted by at most one output per cycle. This is automatic, since each head has exactly one route.
- Latency: a flit accepted at edge k, into an empty FIFO, with the output stage free, is visible on out_valid/out_flit after edge k+1.
  - Sustained throughput is 1 flit/cycle/output.
- Flits are forwarded unmodified.
- Per-input ordering is preserved. No ordering guarantee exists across different inputs.
- local_rx_count increments on every edge where out_valid[0] && out_ready[0].
- Reset mid-operation discards all buffered and in-flight flits. Outputs drop to 0 on the reset edge.

Test Plan:
- Reset, then drive in_valid=0 for 3 cycles → out_valid=0, in_ready=5'b11111, local_rx_count=0.
- Node (1,1). Send on port 0 flit y=1,x=3,data=32'hDEAD_BEEF at edge k, with out_ready=all-1 → out_valid=5'b00100 after edge k+1, out_flit[2]=same flit; a one-cycle pulse.
- Send flits on left, up and down in the same cycle, all to (1,1), with out_ready[0]=1 → local port delivers left, up, down on 3 consecutive cycles in that order; local_rx_count=3.
  - Repeat immediately after → order restarts from the index after down (4), i.e. left, up, down again since local is idle.
- Hold out_ready[2]=0. Push 5 flits into port 1, all destined x=5 → 1 flit sits in the output register and 4 fill the FIFO; in_ready[1]=0.
  - Release ready → 5 flits emerge in push order on 5 consecutive cycles.
- Assert rst for 1 cycle while FIFOs hold 3 flits and out_valid[3]=1 → all out_valid=0 next cycle and no stale flit is emitted afterward.
- Push 65536 local loopback flits (y=1,x=1) → local_rx_count wraps to 0.
